// File: rtl/insight_tl_pkg.sv
// Shared types and helpers for the Insight TileLink latency monitor.
// Widths here are the defaults the top-level parameters inherit.
package insight_tl_pkg;

  localparam int TL_SOURCE_BITS     = 4;
  localparam int TL_ADDR_BITS       = 32;
  localparam int TL_SIZE_BITS       = 3;
  localparam int TL_BEAT_BYTES_LOG2 = 3;
  localparam int TL_LAT_BITS        = 16;

  typedef enum logic [2:0] {
    A_PUT_FULL      = 3'd0,
    A_PUT_PARTIAL   = 3'd1,
    A_ARITHMETIC    = 3'd2,
    A_LOGICAL       = 3'd3,
    A_GET           = 3'd4,
    A_HINT          = 3'd5,
    A_ACQUIRE_BLOCK = 3'd6,
    A_ACQUIRE_PERM  = 3'd7
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2,
    D_GRANT           = 3'd4,
    D_GRANT_DATA      = 3'd5,
    D_RELEASE_ACK     = 3'd6
  } d_opcode_e;

  typedef struct packed {
    logic [TL_SOURCE_BITS-1:0] source;
    logic [2:0]                opcode;
    logic [TL_ADDR_BITS-1:0]   address;
    logic [TL_LAT_BITS-1:0]    latency;
    logic                      error;
  } rec_t;

  function automatic logic a_has_data(input logic [2:0] opcode);
    return opcode <= 3'd3;
  endfunction

  function automatic logic d_has_data(input logic [2:0] opcode);
    return (opcode == 3'd1) || (opcode == 3'd5);
  endfunction

  // Only data-carrying messages larger than one bus beat span several beats.
  function automatic logic [15:0] tl_beats(input logic has_data,
                                           input logic [TL_SIZE_BITS-1:0] size,
                                           input int beat_log2);
    if (has_data && (int'(size) > beat_log2))
      return 16'd1 << (int'(size) - beat_log2);
    return 16'd1;
  endfunction

endpackage

// File: rtl/insight_tl_rec_fifo.sv
// Record buffer for completed transactions; read data comes straight from storage flops.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module insight_tl_rec_fifo
  import insight_tl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (PW+1)'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/insight_hart_0_tl_latency_monitor.sv
// Passive A/D channel observer: pairs requests and responses by source ID and
// emits one latency record per completed transaction, flagging protocol anomalies.
module insight_hart_0_tl_latency_monitor
  import insight_tl_pkg::*;
#(
  parameter int SOURCE_BITS     = TL_SOURCE_BITS,
  parameter int ADDR_BITS       = TL_ADDR_BITS,
  parameter int SIZE_BITS       = TL_SIZE_BITS,
  parameter int BEAT_BYTES_LOG2 = TL_BEAT_BYTES_LOG2,
  parameter int LAT_BITS        = TL_LAT_BITS,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [SOURCE_BITS-1:0] rec_source,
  output logic [2:0]             rec_opcode,
  output logic [ADDR_BITS-1:0]   rec_address,
  output logic [LAT_BITS-1:0]    rec_latency,
  output logic                   rec_error,
  output logic [SOURCE_BITS:0]   outstanding,
  output logic [15:0]            drop_count,
  output logic                   err_orphan,
  output logic                   err_dup
);

  localparam int N = 2**SOURCE_BITS;

  logic [LAT_BITS-1:0]  ts_q, ts_d;
  logic [15:0]          a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
  logic [15:0]          a_beats, d_beats;
  logic [N-1:0]         tbl_valid_q, tbl_valid_d, tbl_err_q, tbl_err_d;
  logic [LAT_BITS-1:0]  tbl_ts_q   [N];
  logic [LAT_BITS-1:0]  tbl_ts_d   [N];
  logic [2:0]           tbl_op_q   [N];
  logic [2:0]           tbl_op_d   [N];
  logic [ADDR_BITS-1:0] tbl_addr_q [N];
  logic [ADDR_BITS-1:0] tbl_addr_d [N];
  logic [SOURCE_BITS:0] outstanding_q, outstanding_d;
  logic [15:0]          drop_count_q, drop_count_d;
  logic                 err_orphan_q, err_orphan_d, err_dup_q, err_dup_d;
  logic                 a_fire, d_fire, a_open, d_last_fire, d_close, same_src_close;
  logic                 fifo_full, fifo_empty, rec_pop;
  rec_t                 push_rec, head_rec;

  always_comb begin
    ts_d        = ts_q + 1'b1;
    a_fire      = a_valid & a_ready;
    d_fire      = d_valid & d_ready;
    a_beats     = tl_beats(a_has_data(a_opcode), a_size, BEAT_BYTES_LOG2);
    d_beats     = tl_beats(d_has_data(d_opcode), d_size, BEAT_BYTES_LOG2);
    a_open      = a_fire & (a_cnt_q == '0);
    d_last_fire = d_fire & (d_cnt_q == d_beats - 16'd1);
    a_cnt_d     = a_cnt_q;
    d_cnt_d     = d_cnt_q;
    if (a_fire) a_cnt_d = (a_cnt_q == a_beats - 16'd1) ? '0 : a_cnt_q + 16'd1;
    if (d_fire) d_cnt_d = d_last_fire ? '0 : d_cnt_q + 16'd1;
    d_close        = d_last_fire & tbl_valid_q[d_source];
    same_src_close = d_close & (d_source == a_source);
  end

  // D is applied before A so a same-cycle close-then-reopen of one source works.
  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_err_d   = tbl_err_q;
    tbl_ts_d    = tbl_ts_q;
    tbl_op_d    = tbl_op_q;
    tbl_addr_d  = tbl_addr_q;
    if (d_fire && tbl_valid_q[d_source])
      tbl_err_d[d_source] = tbl_err_q[d_source] | d_corrupt | d_denied;
    if (d_close) tbl_valid_d[d_source] = 1'b0;
    if (a_open) begin
      tbl_valid_d[a_source] = 1'b1;
      tbl_err_d[a_source]   = 1'b0;
      tbl_ts_d[a_source]    = ts_q;
      tbl_op_d[a_source]    = a_opcode;
      tbl_addr_d[a_source]  = a_address;
    end
    outstanding_d = '0;
    for (int i = 0; i < N; i++)
      outstanding_d = outstanding_d + (SOURCE_BITS+1)'(tbl_valid_d[i]);
  end

  always_comb begin
    push_rec.source  = d_source;
    push_rec.opcode  = tbl_op_q[d_source];
    push_rec.address = tbl_addr_q[d_source];
    push_rec.latency = ts_q - tbl_ts_q[d_source];
    push_rec.error   = tbl_err_q[d_source] | d_corrupt | d_denied;
    rec_pop          = ~fifo_empty & rec_ready;
    drop_count_d     = drop_count_q;
    if (d_close && fifo_full && !rec_pop && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;
    err_orphan_d = err_orphan_q | (d_last_fire & ~tbl_valid_q[d_source]);
    err_dup_d    = err_dup_q | (a_open & tbl_valid_q[a_source] & ~same_src_close);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q          <= '0;
      a_cnt_q       <= '0;
      d_cnt_q       <= '0;
      tbl_valid_q   <= '0;
      tbl_err_q     <= '0;
      for (int i = 0; i < N; i++) begin
        tbl_ts_q[i]   <= '0;
        tbl_op_q[i]   <= '0;
        tbl_addr_q[i] <= '0;
      end
      outstanding_q <= '0;
      drop_count_q  <= '0;
      err_orphan_q  <= 1'b0;
      err_dup_q     <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      a_cnt_q       <= a_cnt_d;
      d_cnt_q       <= d_cnt_d;
      tbl_valid_q   <= tbl_valid_d;
      tbl_err_q     <= tbl_err_d;
      tbl_ts_q      <= tbl_ts_d;
      tbl_op_q      <= tbl_op_d;
      tbl_addr_q    <= tbl_addr_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      err_orphan_q  <= err_orphan_d;
      err_dup_q     <= err_dup_d;
    end
  end

  insight_tl_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (d_close),
    .push_data (push_rec),
    .pop       (rec_pop),
    .rd_data   (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid   = ~fifo_empty;
  assign rec_source  = head_rec.source;
  assign rec_opcode  = head_rec.opcode;
  assign rec_address = head_rec.address;
  assign rec_latency = head_rec.latency;
  assign rec_error   = head_rec.error;
  assign outstanding = outstanding_q;
  assign drop_count  = drop_count_q;
  assign err_orphan  = err_orphan_q;
  assign err_dup     = err_dup_q;

endmodule

// File: tb/tb_insight_hart_0_tl_latency_monitor.sv
// Scoreboard bench: expected records are queued when the closing D beat is driven
// and compared by a monitor whenever the DUT hands a record over.
module tb_insight_hart_0_tl_latency_monitor;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_valid, a_ready, d_valid, d_ready, d_denied, d_corrupt, rec_ready;
  logic [2:0]  a_opcode, a_size, d_opcode, d_size;
  logic [3:0]  a_source, d_source;
  logic [31:0] a_address;
  logic        rec_valid, rec_error, err_orphan, err_dup;
  logic [3:0]  rec_source;
  logic [2:0]  rec_opcode;
  logic [31:0] rec_address;
  logic [15:0] rec_latency, drop_count;
  logic [4:0]  outstanding;

  typedef struct {
    logic [3:0]  src;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [15:0] lat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  insight_hart_0_tl_latency_monitor dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_source(rec_source),
    .rec_opcode(rec_opcode), .rec_address(rec_address), .rec_latency(rec_latency),
    .rec_error(rec_error), .outstanding(outstanding), .drop_count(drop_count),
    .err_orphan(err_orphan), .err_dup(err_dup)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n && rec_valid && rec_ready) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL rec_unexpected: got src=%0d lat=%0d, required no record", rec_source, rec_latency);
      end else begin
        mon_e = sb.pop_front();
        if (rec_source !== mon_e.src || rec_opcode !== mon_e.op || rec_address !== mon_e.addr ||
            rec_latency !== mon_e.lat || rec_error !== mon_e.err)
          $display("FAIL rec_fields: got src=%0d op=%0d addr=%h lat=%0d err=%0b, required src=%0d op=%0d addr=%h lat=%0d err=%0b",
                   rec_source, rec_opcode, rec_address, rec_latency, rec_error,
                   mon_e.src, mon_e.op, mon_e.addr, mon_e.lat, mon_e.err);
        else n_pass++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    d_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic put_a(input logic [3:0] src, input logic [2:0] op, input logic [2:0] size,
                       input logic [31:0] addr);
    a_valid = 1'b1; a_source = src; a_opcode = op; a_size = size; a_address = addr;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic put_d(input logic [3:0] src, input logic [2:0] op, input logic [2:0] size);
    d_valid = 1'b1; d_source = src; d_opcode = op; d_size = size;
    tick();
    d_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && (sb.size() != 0 || rec_valid); i++) tick();
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    d_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_total++; if (rec_valid !== 1'b0) $display("FAIL reset_rec_valid: got %0b, required 0", rec_valid); else n_pass++;
    n_total++; if (outstanding !== 5'd0) $display("FAIL reset_outstanding: got %0d, required 0", outstanding); else n_pass++;
    n_total++; if (drop_count !== 16'd0) $display("FAIL reset_drop_count: got %0d, required 0", drop_count); else n_pass++;
    n_total++; if ({err_orphan, err_dup} !== 2'b00) $display("FAIL reset_flags: got %b, required 00", {err_orphan, err_dup}); else n_pass++;
    n_total++; if (rec_latency !== 16'd0) $display("FAIL reset_rec_latency: got %0d, required 0", rec_latency); else n_pass++;
  endtask

  task automatic test_basic_get();
    put_a(4'd3, 3'd4, 3'd3, 32'h0000_1000);
    n_total++; if (outstanding !== 5'd1) $display("FAIL basic_outstanding_open: got %0d, required 1", outstanding); else n_pass++;
    idle(14);
    sb.push_back('{4'd3, 3'd4, 32'h0000_1000, 16'd15, 1'b0});
    put_d(4'd3, 3'd1, 3'd3);
    n_total++; if (rec_valid !== 1'b1) $display("FAIL basic_rec_visible: got %0b, required 1", rec_valid); else n_pass++;
    n_total++; if (outstanding !== 5'd0) $display("FAIL basic_outstanding_closed: got %0d, required 0", outstanding); else n_pass++;
    wait_drain();
    n_total++; if (sb.size() != 0) $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); else n_pass++;
  endtask

  task automatic test_burst_put();
    a_valid = 1'b1; a_source = 4'd1; a_opcode = 3'd0; a_size = 3'd6; a_address = 32'h0000_0100;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        a_ready = 1'b0;
        tick();
        a_ready = 1'b1;
      end
      tick();
    end
    a_valid = 1'b0;
    n_total++; if (outstanding !== 5'd1) $display("FAIL burst_outstanding: got %0d, required 1", outstanding); else n_pass++;
    n_total++; if (err_dup !== 1'b0) $display("FAIL burst_no_dup: got %0b, required 0", err_dup); else n_pass++;
    idle(3);
    sb.push_back('{4'd1, 3'd0, 32'h0000_0100, 16'd12, 1'b0});
    put_d(4'd1, 3'd0, 3'd6);
    wait_drain();
    n_total++; if (sb.size() != 0 || rec_valid !== 1'b0) $display("FAIL burst_one_record: got %0d pending valid=%0b, required 0", sb.size(), rec_valid); else n_pass++;
  endtask

  task automatic test_orphan();
    put_d(4'd5, 3'd0, 3'd0);
    n_total++; if (err_orphan !== 1'b1) $display("FAIL orphan_flag: got %0b, required 1", err_orphan); else n_pass++;
    n_total++; if (rec_valid !== 1'b0) $display("FAIL orphan_no_record: got %0b, required 0", rec_valid); else n_pass++;
    idle(5);
    n_total++; if (err_orphan !== 1'b1) $display("FAIL orphan_sticky: got %0b, required 1", err_orphan); else n_pass++;
    do_reset();
    n_total++; if (err_orphan !== 1'b0) $display("FAIL orphan_cleared: got %0b, required 0", err_orphan); else n_pass++;
  endtask

  task automatic test_dup();
    put_a(4'd2, 3'd4, 3'd3, 32'h0000_2000);
    idle(2);
    put_a(4'd2, 3'd4, 3'd3, 32'h0000_2200);
    n_total++; if (err_dup !== 1'b1) $display("FAIL dup_flag: got %0b, required 1", err_dup); else n_pass++;
    n_total++; if (outstanding !== 5'd1) $display("FAIL dup_outstanding: got %0d, required 1", outstanding); else n_pass++;
    idle(4);
    sb.push_back('{4'd2, 3'd4, 32'h0000_2200, 16'd5, 1'b0});
    put_d(4'd2, 3'd1, 3'd3);
    wait_drain();
    n_total++; if (sb.size() != 0) $display("FAIL dup_drain: got %0d pending, required 0", sb.size()); else n_pass++;
    do_reset();
    n_total++; if (err_dup !== 1'b0) $display("FAIL dup_cleared: got %0b, required 0", err_dup); else n_pass++;
  endtask

  task automatic test_same_cycle();
    put_a(4'd6, 3'd4, 3'd3, 32'h0000_6000);
    idle(2);
    a_valid = 1'b1; a_source = 4'd6; a_opcode = 3'd1; a_size = 3'd3; a_address = 32'h0000_6100;
    d_valid = 1'b1; d_source = 4'd6; d_opcode = 3'd1; d_size = 3'd3;
    sb.push_back('{4'd6, 3'd4, 32'h0000_6000, 16'd3, 1'b0});
    tick();
    idle(0);
    n_total++; if (err_dup !== 1'b0) $display("FAIL same_no_dup: got %0b, required 0", err_dup); else n_pass++;
    n_total++; if (outstanding !== 5'd1) $display("FAIL same_reopen: got %0d, required 1", outstanding); else n_pass++;
    idle(1);
    sb.push_back('{4'd6, 3'd1, 32'h0000_6100, 16'd2, 1'b0});
    put_d(4'd6, 3'd0, 3'd3);
    a_valid = 1'b1; a_source = 4'd7; a_opcode = 3'd4; a_size = 3'd3; a_address = 32'h0000_7000;
    d_valid = 1'b1; d_source = 4'd7; d_opcode = 3'd0; d_size = 3'd0;
    tick();
    idle(0);
    n_total++; if (err_orphan !== 1'b1) $display("FAIL same_orphan: got %0b, required 1", err_orphan); else n_pass++;
    idle(1);
    sb.push_back('{4'd7, 3'd4, 32'h0000_7000, 16'd2, 1'b0});
    put_d(4'd7, 3'd1, 3'd3);
    wait_drain();
    n_total++; if (sb.size() != 0 || outstanding !== 5'd0) $display("FAIL same_drain: got %0d pending outstanding=%0d, required 0", sb.size(), outstanding); else n_pass++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    int held;
    int t7;
    held = 0;
    rec_ready = 1'b0;
    put_a(4'd7, 3'd4, 3'd3, 32'h0000_7700);
    t7 = cyc;
    for (int i = 0; i < 6; i++) begin
      put_a(4'(i), 3'd4, 3'd3, 32'(i) * 32'h100);
      put_d(4'(i), 3'd1, 3'd3);
      if (held < 4) begin
        sb.push_back('{4'(i), 3'd4, 32'(i) * 32'h100, 16'd1, 1'b0});
        held++;
      end
    end
    idle(3);
    n_total++; if (rec_valid !== 1'b1) $display("FAIL bp_held_valid: got %0b, required 1", rec_valid); else n_pass++;
    n_total++; if (drop_count !== 16'd2) $display("FAIL bp_drop_count: got %0d, required 2", drop_count); else n_pass++;
    n_total++; if (rec_source !== sb[0].src || rec_address !== sb[0].addr) $display("FAIL bp_head_stable: got src=%0d addr=%h, required src=%0d addr=%h", rec_source, rec_address, sb[0].src, sb[0].addr); else n_pass++;
    n_total++; if (outstanding !== 5'd1) $display("FAIL bp_outstanding: got %0d, required 1", outstanding); else n_pass++;
    rec_ready = 1'b1;
    d_valid = 1'b1; d_source = 4'd7; d_opcode = 3'd1; d_size = 3'd3;
    sb.push_back('{4'd7, 3'd4, 32'h0000_7700, 16'(cyc + 1 - t7), 1'b0});
    tick();
    d_valid = 1'b0;
    n_total++; if (drop_count !== 16'd2) $display("FAIL bp_full_with_pop: got %0d, required 2", drop_count); else n_pass++;
    wait_drain();
    n_total++; if (sb.size() != 0 || rec_valid !== 1'b0) $display("FAIL bp_drain: got %0d pending valid=%0b, required 0", sb.size(), rec_valid); else n_pass++;
  endtask

  task automatic test_corrupt_reset();
    put_a(4'd4, 3'd6, 3'd5, 32'h0000_4000);
    idle(1);
    sb.push_back('{4'd4, 3'd6, 32'h0000_4000, 16'd5, 1'b1});
    d_valid = 1'b1; d_source = 4'd4; d_opcode = 3'd5; d_size = 3'd5;
    for (int i = 0; i < 4; i++) begin
      d_corrupt = (i == 1);
      tick();
    end
    d_valid = 1'b0;
    d_corrupt = 1'b0;
    wait_drain();
    n_total++; if (sb.size() != 0) $display("FAIL corrupt_drain: got %0d pending, required 0", sb.size()); else n_pass++;
    put_a(4'd4, 3'd6, 3'd5, 32'h0000_4100);
    put_a(4'd9, 3'd4, 3'd3, 32'h0000_9000);
    n_total++; if (outstanding !== 5'd2) $display("FAIL corrupt_two_open: got %0d, required 2", outstanding); else n_pass++;
    d_valid = 1'b1; d_source = 4'd4; d_opcode = 3'd5; d_size = 3'd5;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_total++; if (rec_valid !== 1'b0 || outstanding !== 5'd0) $display("FAIL midreset_state: got valid=%0b outstanding=%0d, required 0", rec_valid, outstanding); else n_pass++;
    n_total++; if (drop_count !== 16'd0) $display("FAIL midreset_drop_count: got %0d, required 0", drop_count); else n_pass++;
    n_total++; if ({err_orphan, err_dup, rec_error} !== 3'b000 || rec_latency !== 16'd0 || rec_source !== 4'd0) $display("FAIL midreset_outputs: got flags=%b lat=%0d src=%0d, required 0", {err_orphan, err_dup, rec_error}, rec_latency, rec_source); else n_pass++;
    d_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    put_d(4'd9, 3'd1, 3'd3);
    n_total++; if (err_orphan !== 1'b1 || rec_valid !== 1'b0) $display("FAIL postreset_orphan: got orphan=%0b valid=%0b, required 1 0", err_orphan, rec_valid); else n_pass++;
  endtask

  initial begin
    a_valid = 1'b0; a_ready = 1'b1; a_opcode = 3'd0; a_size = 3'd0; a_source = 4'd0; a_address = '0;
    d_valid = 1'b0; d_ready = 1'b1; d_opcode = 3'd0; d_size = 3'd0; d_source = 4'd0;
    d_denied = 1'b0; d_corrupt = 1'b0; rec_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_basic_get();
    test_burst_put();
    test_orphan();
    test_dup();
    test_same_cycle();
    test_back_to_back();
    test_corrupt_reset();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
